// File: rtl/adc_sample_framer_pkg.sv
// Shared constants, FSM encoding and byte-builder helpers for the ADC sample framer.
// Build option: define ADC_FRAMER_SEQ_EN to carry the 2-bit sample sequence number
// in FIFO words and HI bytes; without it the HI sequence field is always 2'b00.
package adc_sample_framer_pkg;

   localparam int ADC_RES     = 12;
   localparam int SEQ_W       = 2;
   localparam int SYNC_BIT    = 7;

   // HI byte = {sync=1, seq[1:0], data[11:7]}
   localparam int HI_SEQ_MSB  = 6;
   localparam int HI_SEQ_LSB  = 5;
   localparam int HI_DATA_MSB = 4;
   localparam int HI_DATA_W   = 5;

   // LO byte = {sync=0, data[6:0]}
   localparam int LO_DATA_MSB = 6;
   localparam int LO_DATA_W   = 7;

`ifdef ADC_FRAMER_SEQ_EN
   localparam int WORD_W      = ADC_RES + SEQ_W;
`else
   localparam int WORD_W      = ADC_RES;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } frame_state_t;

   function automatic logic [7:0] make_hi(input logic [SEQ_W-1:0]     seq,
                                          input logic [HI_DATA_W-1:0] hi_bits);
      logic [7:0] b;
      b                           = '0;
      b[SYNC_BIT]                 = 1'b1;
      b[HI_SEQ_MSB:HI_SEQ_LSB]    = seq;
      b[HI_DATA_MSB:0]            = hi_bits;
      return b;
   endfunction

   function automatic logic [7:0] make_lo(input logic [LO_DATA_W-1:0] lo_bits);
      logic [7:0] b;
      b                  = '0;
      b[SYNC_BIT]        = 1'b0;
      b[LO_DATA_MSB:0]   = lo_bits;
      return b;
   endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the oldest word.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
// flush empties the FIFO synchronously; stored words are left in place but become unreachable.
module adc_sample_fifo #(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count_q;
   logic              do_wr;
   logic              do_rd;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem[rd_ptr];

   assign do_rd   = rd_en && !empty && !flush;
   assign do_wr   = wr_en && (!full || do_rd) && !flush;

   // Storage array: data only, no reset needed
   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping; simultaneous read and write leave count unchanged
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)      count_q <= count_q + (AW+1)'(1);
         else if (!do_wr && do_rd) count_q <= count_q - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/adc_sample_framer.sv
// ADC sample framer: buffers 12-bit samples from the ADC reader and emits each one
// as a two-byte self-synchronising frame (HI with sync bit set, then LO) on a
// valid/ready byte stream towards the UART transmitter.
// Build option: ADC_FRAMER_SEQ_EN adds a 2-bit per-sample sequence number (counted
// on every sample pulse, dropped or not) into the HI byte so the host can spot gaps.
module adc_sample_framer
   import adc_sample_framer_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          clear,
   input  logic                          sample_ready,
   input  logic [11:0]                   sample_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [7:0]                    tx_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   frame_state_t        state;
   frame_state_t        state_nxt;

   logic [WORD_W-1:0]   fifo_wr_word;
   logic [WORD_W-1:0]   fifo_rd_word;
   logic                fifo_full;
   logic                fifo_empty;

   logic [SEQ_W-1:0]    word_seq;
   logic [ADC_RES-1:0]  word_data;
   logic [LO_DATA_W-1:0] lo_hold;

   logic                transfer;
   logic                pop;
   logic                push;
   logic                drop;
   logic                load_hi;
   logic                load_lo;
   logic                valid_nxt;

   assign transfer = tx_valid && tx_ready;

`ifdef ADC_FRAMER_SEQ_EN
   logic [SEQ_W-1:0]    seq;

   // Sequence counter advances on every sample pulse so dropped samples leave a gap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          seq <= '0;
      else if (clear)        seq <= '0;
      else if (sample_ready) seq <= seq + SEQ_W'(1);
   end

   assign fifo_wr_word = {seq, sample_data};
   assign word_seq     = fifo_rd_word[WORD_W-1 -: SEQ_W];
   assign word_data    = fifo_rd_word[ADC_RES-1:0];
`else
   assign fifo_wr_word = sample_data;
   assign word_seq     = '0;
   assign word_data    = fifo_rd_word;
`endif

   // A full FIFO still accepts a sample when the framer pops in the same cycle
   assign push = sample_ready && !clear && (!fifo_full || pop);
   assign drop = sample_ready && !clear && !push;

   adc_sample_fifo #(
      .DATA_W (WORD_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (clear),
      .wr_en   (push),
      .wr_data (fifo_wr_word),
      .rd_en   (pop),
      .rd_data (fifo_rd_word),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Sticky drop flag, only cleared by clear or reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   overflow <= 1'b0;
      else if (clear) overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
   end

   // Framer state register; clear abandons any frame in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   state <= ST_IDLE;
      else if (clear) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // Next-state logic: HI and LO advance only on an accepted byte
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (!fifo_empty) state_nxt = ST_HI;
         ST_HI:   if (transfer)    state_nxt = ST_LO;
         ST_LO:   if (transfer)    state_nxt = fifo_empty ? ST_IDLE : ST_HI;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   // Output decode: pop and byte-load strobes; LO chains straight into the next HI
   always_comb begin
      pop       = 1'b0;
      load_hi   = 1'b0;
      load_lo   = 1'b0;
      valid_nxt = tx_valid;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               load_hi   = 1'b1;
               valid_nxt = 1'b1;
            end
         end
         ST_HI: begin
            if (transfer) load_lo = 1'b1;
         end
         ST_LO: begin
            if (transfer) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  load_hi   = 1'b1;
                  valid_nxt = 1'b1;
               end else begin
                  valid_nxt = 1'b0;
               end
            end
         end
         default: valid_nxt = 1'b0;
      endcase
   end

   // Registered byte stream; tx_data only reloads on a handshake or from idle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else if (clear) begin
         tx_valid <= 1'b0;
      end else begin
         tx_valid <= valid_nxt;
         if (load_hi)      tx_data <= make_hi(word_seq, word_data[ADC_RES-1:LO_DATA_W]);
         else if (load_lo) tx_data <= make_lo(lo_hold);
      end
   end

   // Low seven data bits of the popped word, held until the LO byte is built
   always_ff @(posedge clock) begin
      if (load_hi) lo_hold <= word_data[LO_DATA_W-1:0];
   end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed self-checking bench for adc_sample_framer (FIFO_DEPTH = 4).
// Expected HI bytes are written for the sequence-enabled build and have their
// sequence bits masked off when ADC_FRAMER_SEQ_EN is not defined.
module tb_adc_sample_framer;

   localparam int DEPTH = 4;
`ifdef ADC_FRAMER_SEQ_EN
   localparam bit SEQ_ON = 1'b1;
`else
   localparam bit SEQ_ON = 1'b0;
`endif

   logic        clock        = 1'b0;
   logic        reset_n      = 1'b0;
   logic        clear        = 1'b0;
   logic        sample_ready = 1'b0;
   logic [11:0] sample_data  = 12'h000;
   logic        tx_ready     = 1'b0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic [2:0]  fifo_count;
   logic        overflow;

   int          n_cmp = 0;
   int          n_bad = 0;

   logic [7:0]  got [0:31];
   int          got_n;
   int          gaps;
   logic [11:0] stim [0:7];
   int          stim_n;

   always #5 clock = ~clock;

   adc_sample_framer #(.FIFO_DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .clear        (clear),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   function automatic logic [7:0] hi_exp(input logic [7:0] b);
      return SEQ_ON ? b : (b & 8'h9F);
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_clear;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Pulse stim[0..stim_n-1] on consecutive cycles while recording accepted bytes
   task automatic run(input int n_bytes, input int budget);
      bit started;
      started = 1'b0;
      got_n   = 0;
      gaps    = 0;
      for (int c = 0; c < budget && got_n < n_bytes; c++) begin
         sample_ready = (c < stim_n);
         sample_data  = (c < stim_n) ? stim[c] : 12'h000;
         if (tx_valid) started = 1'b1;
         else if (started) gaps++;
         if (tx_valid && tx_ready) begin
            got[got_n] = tx_data;
            got_n++;
         end
         tick();
      end
      sample_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick();
      tick();
      n_cmp++; if (tx_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
      n_cmp++; if (tx_data !== 8'h00)    begin n_bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      n_cmp++; if (fifo_count !== 3'd0)  begin n_bad++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
      n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single;
      tx_ready     = 1'b1;
      sample_ready = 1'b1;
      sample_data  = 12'hABC;
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_c0 got %b want 0", tx_valid); end
      tick();
      sample_ready = 1'b0;
      n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_count_c1 got %0d want 1", fifo_count); end
      n_cmp++; if (tx_valid !== 1'b0)   begin n_bad++; $display("FAIL single_valid_c1 got %b want 0", tx_valid); end
      tick();
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h95}) begin n_bad++; $display("FAIL single_hi got %b/%h want 1/95", tx_valid, tx_data); end
      tick();
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL single_lo got %b/%h want 1/3c", tx_valid, tx_data); end
      tick();
      n_cmp++; if (tx_valid !== 1'b0)   begin n_bad++; $display("FAIL single_idle_valid got %b want 0", tx_valid); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL single_idle_count got %0d want 0", fifo_count); end
   endtask

   task automatic test_four;
      logic [7:0] want [0:7];
      want[0] = hi_exp(8'h80); want[1] = 8'h00;
      want[2] = hi_exp(8'hBF); want[3] = 8'h7F;
      want[4] = hi_exp(8'hC1); want[5] = 8'h00;
      want[6] = hi_exp(8'hE0); want[7] = 8'h7F;
      do_clear();
      tx_ready = 1'b1;
      stim[0] = 12'h000; stim[1] = 12'hFFF; stim[2] = 12'h080; stim[3] = 12'h07F;
      stim_n = 4;
      run(8, 30);
      stim_n = 0;
      n_cmp++; if (got_n !== 8) begin n_bad++; $display("FAIL four_byte_count got %0d want 8", got_n); end
      n_cmp++; if (gaps !== 0)  begin n_bad++; $display("FAIL four_gaps got %0d want 0", gaps); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin n_bad++; $display("FAIL four_byte%0d got %h want %h", i, got[i], want[i]); end
      end
   endtask

   task automatic test_stall;
      do_clear();
      tx_ready     = 1'b0;
      sample_ready = 1'b1;
      sample_data  = 12'h123;
      tick();
      sample_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({tx_valid, tx_data} !== {1'b1, 8'h82}) begin n_bad++; $display("FAIL stall_hold%0d got %b/%h want 1/82", i, tx_valid, tx_data); end
         tick();
      end
      tx_ready = 1'b1;
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h82}) begin n_bad++; $display("FAIL stall_release got %b/%h want 1/82", tx_valid, tx_data); end
      tick();
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h23}) begin n_bad++; $display("FAIL stall_lo got %b/%h want 1/23", tx_valid, tx_data); end
      tick();
      n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL stall_end_valid got %b want 0", tx_valid); end
   endtask

   task automatic test_overflow;
      logic [7:0] want [0:9];
      want[0] = hi_exp(8'hA1); want[1] = 8'h01;
      want[2] = hi_exp(8'hC2); want[3] = 8'h02;
      want[4] = hi_exp(8'hE3); want[5] = 8'h03;
      want[6] = hi_exp(8'h84); want[7] = 8'h04;
      want[8] = hi_exp(8'hC6); want[9] = 8'h06;
      do_clear();
      tx_ready = 1'b0;
      // sample i carries {hi5 = i, lo7 = i}; one goes to the byte register, four fill the FIFO, one is dropped
      for (int i = 0; i < DEPTH + 2; i++) begin
         sample_ready = 1'b1;
         sample_data  = {5'(i), 7'(i)};
         tick();
      end
      sample_ready = 1'b0;
      n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
      n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, hi_exp(8'h80)}) begin n_bad++; $display("FAIL ovf_head got %b/%h want 1/%h", tx_valid, tx_data, hi_exp(8'h80)); end
      tx_ready = 1'b1;
      tick();
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL ovf_head_lo got %b/%h want 1/00", tx_valid, tx_data); end
      // LO accepted and next word popped in this cycle, so a push into the full FIFO must be taken
      sample_ready = 1'b1;
      sample_data  = {5'd6, 7'd6};
      tick();
      sample_ready = 1'b0;
      n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_pushpop_count got %0d want 4", fifo_count); end
      n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      stim_n = 0;
      run(10, 40);
      n_cmp++; if (got_n !== 10) begin n_bad++; $display("FAIL ovf_drain_count got %0d want 10", got_n); end
      n_cmp++; if (gaps !== 0)   begin n_bad++; $display("FAIL ovf_drain_gaps got %0d want 0", gaps); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin n_bad++; $display("FAIL ovf_drain%0d got %h want %h", i, got[i], want[i]); end
      end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL ovf_empty got %0d want 0", fifo_count); end
   endtask

   // Runs straight after test_overflow: overflow is still set and seq is non-zero
   task automatic test_clear_mid;
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample_ready = 1'b1;
         sample_data  = 12'h111 * 12'(i + 1);
         tick();
      end
      sample_ready = 1'b0;
      n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL clr_queued got %0d want 3", fifo_count); end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      n_cmp++; if ({tx_valid, tx_data[7]} !== 2'b10) begin n_bad++; $display("FAIL clr_in_lo got %b/%h want valid LO byte", tx_valid, tx_data); end
      clear        = 1'b1;
      sample_ready = 1'b1;
      sample_data  = 12'hFFF;
      tick();
      clear        = 1'b0;
      sample_ready = 1'b0;
      n_cmp++; if (tx_valid !== 1'b0)   begin n_bad++; $display("FAIL clr_valid got %b want 0", tx_valid); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL clr_count got %0d want 0", fifo_count); end
      n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL clr_overflow got %b want 0", overflow); end
      tx_ready = 1'b1;
      stim[0]  = 12'hABC;
      stim_n   = 1;
      run(2, 10);
      stim_n   = 0;
      n_cmp++; if (got_n !== 2) begin n_bad++; $display("FAIL clr_next_count got %0d want 2", got_n); end
      n_cmp++; if (got[0] !== 8'h95) begin n_bad++; $display("FAIL clr_next_hi got %h want 95", got[0]); end
      n_cmp++; if (got[1] !== 8'h3C) begin n_bad++; $display("FAIL clr_next_lo got %h want 3c", got[1]); end
   endtask

   task automatic test_repeat;
      do_clear();
      tx_ready = 1'b1;
      stim[0]  = 12'hABC;
      stim[1]  = 12'hABC;
      stim_n   = 2;
      run(4, 20);
      stim_n   = 0;
      n_cmp++; if (got_n !== 4) begin n_bad++; $display("FAIL rep_count got %0d want 4", got_n); end
      n_cmp++; if (got[0] !== 8'h95) begin n_bad++; $display("FAIL rep_hi0 got %h want 95", got[0]); end
      n_cmp++; if (got[1] !== 8'h3C) begin n_bad++; $display("FAIL rep_lo0 got %h want 3c", got[1]); end
      n_cmp++; if (got[2] !== hi_exp(8'hB5)) begin n_bad++; $display("FAIL rep_hi1 got %h want %h", got[2], hi_exp(8'hB5)); end
      n_cmp++; if (got[3] !== 8'h3C) begin n_bad++; $display("FAIL rep_lo1 got %h want 3c", got[3]); end
   endtask

   task automatic test_async_reset;
      do_clear();
      tx_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sample_ready = 1'b1;
         sample_data  = 12'h5A5;
         tick();
      end
      sample_ready = 1'b0;
      n_cmp++; if ({tx_valid, fifo_count} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL arst_pre got %b/%0d want 1/1", tx_valid, fifo_count); end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (tx_valid !== 1'b0)   begin n_bad++; $display("FAIL arst_valid got %b want 0", tx_valid); end
      n_cmp++; if (tx_data !== 8'h00)   begin n_bad++; $display("FAIL arst_data got %h want 00", tx_data); end
      n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL arst_count got %0d want 0", fifo_count); end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      stim_n = 0;
      test_reset();
      test_single();
      test_four();
      test_stall();
      test_overflow();
      test_clear_mid();
      test_repeat();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adc_sample_framer.md
# adc_sample_framer

Downstream stage of the LTC2308 ADC reader: captures each 12-bit sample on its one-cycle ready pulse and buffers it in a small FIFO. It then serialises each sample as a self-synchronising two-byte frame over a valid/ready byte stream that feeds the UART transmitter. Byte framing lets the host side realign after drops or a mid-frame flush. A sequence field lets the host detect lost samples.

## Interface
Parameters:
- FIFO_DEPTH, 16, sample FIFO depth in 14-bit words; power of two, ≥2.

Ports:
- clock  in  1  system clock, same clock that drives the ADC reader; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of FIFO, framer state, sequence counter and overflow flag.
- sample_ready  in  1  one-cycle pulse; sample_data valid in that cycle.
- sample_data  in  12  unsigned ADC sample.
- tx_valid  out  1  tx_data holds a byte.
- tx_ready  in  1  UART TX accepts the byte; a transfer occurs on an edge where tx_valid && tx_ready.
- tx_data  out  8  frame byte.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently stored.
- overflow  out  1  sticky; set when a sample is dropped.

## Operation
- Frame per sample:
  - HI = {1'b1, seq[1:0], data[11:7]}.
  - LO = {1'b0, data[6:0]}.
  - Bit 7 is the sync flag.
- seq is a 2-bit counter that increments on every sample_ready pulse, including dropped samples, so the host sees gaps. It wraps 3→0.
- Push: on sample_ready, the word {seq, data} is written if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
- FSM states:
  - IDLE: when FIFO not empty, pop, load HI, tx_valid←1, go to HI.
  - HI: on transfer, load LO, go to LO.
  - LO: on transfer, if FIFO not empty, pop, load next HI, stay valid, go to HI. Otherwise tx_valid←0, go to IDLE.
- tx_data and tx_valid are registered. tx_data must not change while tx_valid && !tx_ready.
- clear wins over simultaneous sample_ready and handshake.
  - Resulting state: FIFO empty, IDLE, tx_valid 0, seq 0, overflow 0.
  - A frame cut mid-way is abandoned; the receiver resyncs on the sync bit.
- Reset values: tx_valid 0, tx_data 8'h00, fifo_count 0, overflow 0, seq 0, state IDLE.
- Async reset mid-frame behaves like clear, immediately.

## Timing
- sample_ready in cycle N: fifo_count increments after edge N.
- If idle and empty: pop at edge N+1, so tx_valid is high in cycle N+2. Latency is 2 cycles.
- Throughput is one byte per cycle while tx_ready is held high. There is no bubble between LO and the next HI.
- Simultaneous push and pop: fifo_count is unchanged.
- Full plus push with no pop: count stays FIFO_DEPTH and overflow rises the next cycle.
- At the 500 kHz ADC rate, a 2-byte frame needs ≥10 Mbaud UART to avoid sustained overflow. The FIFO absorbs bursts only.

## Configuration
- ADC_FRAMER_SEQ_EN:
  - Defined: seq field as described.
  - Undefined: HI bits [6:5] are forced to 2'b00, and the seq counter and its FIFO bits are removed, making FIFO words 12 bits wide.
- Push, drop, and overflow behaviour is identical in both builds.

## Structure
- Shared package/include holds:
  - ADC_RES = 12.
  - SEQ_W = 2.
  - SYNC_BIT = 7.
  - HI/LO field positions.
  - FSM state encodings IDLE/HI/LO.
- Sub-module adc_sample_fifo: synchronous FIFO with write/read/full/empty/count and a flush input, parameterised by width and depth.
- The top level contains the seq counter, drop logic and the framing FSM.

## Test plan
- Single sample 12'hABC, tx_ready=1 → bytes 8'h95, 8'h3C; tx_valid first high 2 cycles after the pulse.
- Four samples 12'h000, 12'hFFF, 12'h080, 12'h07F with tx_ready=1 → 80 00 BF 7F C1 00 E0 7F, with seq 0..3 and no idle cycles between frames.
- tx_ready held low for 5 cycles on HI of 12'h123 → tx_data stays 8'h82 with valid high; the LO byte 8'h23 follows release.
- tx_ready=0, FIFO_DEPTH+2 pulses → fifo_count=FIFO_DEPTH, overflow=1; drained frames show a seq gap of 2 at the end; push+pop while full is accepted.
- clear asserted while in LO with 3 words queued → next cycle tx_valid=0, fifo_count=0, overflow=0; next sample frames with seq=0.
- Without ADC_FRAMER_SEQ_EN, 12'hABC repeated twice → HI byte is 8'h95 both times.
